lsu_mem_ctrl: RTL and testbench

//  Multi-cycle load/store unit with a valid/ready pipeline handshake and a req/gnt/rvalid memory port.

---
 rtl/lsu_mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store unit between EXU and WBU.
// It accepts one access over a valid/ready handshake, issues it on a
// req/gnt/rvalid memory port, and returns the extended load data or the
// fault status to WBU. Only one access is outstanding at a time.
// Optional feature macro: LSU_MISALIGN_CHK_EN. When it is defined,
// misaligned accesses fault without a memory request. When it is not
// defined, the byte offset is rounded down to the access size.
module lsu_mem_ctrl #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_we,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_err,
  output logic                o_mem_req,
  input  logic                i_mem_gnt,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_err
);

  localparam int          STRB_W  = DATA_W / 8;
  localparam int          OFF_W   = $clog2(STRB_W);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, uns_q;
  logic [1:0]          size_q;
  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic [OFF_W-1:0]    in_off, size_mask, off_al;
  logic                fault, accept, timeout_hit;
  logic [DATA_W-1:0]   shifted;
  logic [63:0]         ext;
  logic [DATA_W-1:0]   load_data;

  // Decode the incoming request: aligned offset and fault conditions.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    in_off    = i_addr[OFF_W-1:0];
    size_mask = OFF_W'((4'd1 << i_size) - 4'd1);
    off_al    = in_off & ~size_mask;
    fault     = (DATA_W == 32) && (i_size == 2'd3);
`ifdef LSU_MISALIGN_CHK_EN
    fault     = fault || ((in_off & size_mask) != '0);
`endif
  end

  // Align the returned bus word to the access and extend it to register width.
  always_comb begin
    shifted = i_mem_rdata >> {off_q, 3'b000};
    ext     = 64'(shifted);
    case (size_q)
      2'd0:    ext = {{56{shifted[7]  & ~uns_q}}, shifted[7:0]};
      2'd1:    ext = {{48{shifted[15] & ~uns_q}}, shifted[15:0]};
      2'd2:    ext = {{32{shifted[31] & ~uns_q}}, shifted[31:0]};
      default: ext = 64'(shifted);
    endcase
    load_data = DATA_W'(ext);
  end

  assign timeout_hit = (cnt_q >= TO_LAST);

  // Next-state logic and the response values captured on each transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          accept = 1'b1;
          if (fault) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        // A grant wins; an rvalid in the grant cycle is not a response yet.
        if (i_mem_gnt) begin
          state_d = S_WAIT;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (i_mem_rvalid) begin
          state_d = S_RESP;
          err_d   = i_mem_err;
          rdata_d = (!we_q && !i_mem_err) ? load_data : '0;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        if (i_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timeout counter and response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Latch the accepted request, pre-shifted into bus lanes, for the whole access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      we_q    <= i_we;
      uns_q   <= i_unsigned;
      size_q  <= i_size;
      off_q   <= off_al;
      addr_q  <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      wdata_q <= i_wdata << {off_al, 3'b000};
      wstrb_q <= STRB_W'(((16'd1 << (5'd1 << i_size)) - 16'd1) << off_al);
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_valid     = (state_q == S_RESP);
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl with the default parameters
// (DATA_W = 64, ADDR_W = 64, TIMEOUT = 255).
module tb_lsu_mem_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_we = 1'b0;
  logic [1:0]  i_size = 2'd0;
  logic        i_unsigned = 1'b0;
  logic [63:0] i_addr = '0;
  logic [63:0] i_wdata = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [63:0] o_rdata;
  logic        o_err;
  logic        o_mem_req;
  logic        i_mem_gnt = 1'b0;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_rvalid = 1'b0;
  logic [63:0] i_mem_rdata = '0;
  logic        i_mem_err = 1'b0;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_we         (i_we),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_rdata      (o_rdata),
    .o_err        (o_err),
    .o_mem_req    (o_mem_req),
    .i_mem_gnt    (i_mem_gnt),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wstrb  (o_mem_wstrb),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_err    (i_mem_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request in IDLE for one edge; afterwards the unit is in REQ (or RESP on a fault).
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd);
    check("ready before accept", o_ready, 1'b1);
    i_valid = 1'b1; i_we = we; i_size = sz; i_unsigned = uns;
    i_addr = addr; i_wdata = wd;
    tick();
    i_valid = 1'b0; i_wdata = '0;
  endtask

  // Zero-wait memory: grant in the current REQ cycle, respond the next cycle.
  task automatic respond(input logic [63:0] rd, input logic merr);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = rd; i_mem_err = merr;
    tick();
    i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_err = 1'b0;
  endtask

  // Accept the response and confirm the unit is idle again with cleared outputs.
  task automatic release_resp(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, " idle ready"}, o_ready, 1'b1);
    check({tag, " idle valid"}, o_valid, 1'b0);
    check({tag, " idle err"}, o_err, 1'b0);
    check({tag, " idle rdata"}, o_rdata, 64'h0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] rd, input logic [63:0] exp);
    issue(1'b0, sz, uns, addr, 64'h0);
    check({tag, " req"}, o_mem_req, 1'b1);
    check({tag, " we"}, o_mem_we, 1'b0);
    check({tag, " addr"}, o_mem_addr, {addr[63:3], 3'b000});
    respond(rd, 1'b0);
    check({tag, " valid"}, o_valid, 1'b1);
    check({tag, " rdata"}, o_rdata, exp);
    check({tag, " err"}, o_err, 1'b0);
    release_resp(tag);
  endtask

  initial begin
    int n;

    // Reset state.
    i_rst_n = 1'b0;
    #23;
    check("rst ready", o_ready, 1'b1);
    check("rst valid", o_valid, 1'b0);
    check("rst req", o_mem_req, 1'b0);
    check("rst err", o_err, 1'b0);
    check("rst rdata", o_rdata, 64'h0);
    check("rst addr", o_mem_addr, 64'h0);
    check("rst wstrb", o_mem_wstrb, 8'h00);
    check("rst wdata", o_mem_wdata, 64'h0);
    check("rst we", o_mem_we, 1'b0);
    i_rst_n = 1'b1;
    tick();

    // Stray memory handshakes in IDLE are ignored.
    i_mem_rvalid = 1'b1; i_mem_gnt = 1'b1; i_mem_err = 1'b1;
    tick();
    i_mem_rvalid = 1'b0; i_mem_gnt = 1'b0; i_mem_err = 1'b0;
    check("stray idle valid", o_valid, 1'b0);
    check("stray idle ready", o_ready, 1'b1);

    // LD with minimum latency: accept c0, gnt c1, rvalid c2, o_valid c3.
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0);
    check("ld c1 req", o_mem_req, 1'b1);
    check("ld c1 ready", o_ready, 1'b0);
    check("ld c1 addr", o_mem_addr, 64'h8000_0008);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    check("ld c2 req", o_mem_req, 1'b0);
    check("ld c2 valid", o_valid, 1'b0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h1122_3344_5566_7788;
    tick();
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    check("ld c3 valid", o_valid, 1'b1);
    check("ld c3 rdata", o_rdata, 64'h1122_3344_5566_7788);
    check("ld c3 err", o_err, 1'b0);
    release_resp("ld");

    // Sub-word loads: lane shifting with sign and zero extension.
    do_load("lb",  2'd0, 1'b0, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", 2'd0, 1'b1, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    do_load("lhu", 2'd1, 1'b1, 64'h8000_0002, 64'h0000_0000_ABCD_0000, 64'h0000_0000_0000_ABCD);
    do_load("lh",  2'd1, 1'b0, 64'h8000_000E, 64'hF00D_0000_0000_0000, 64'hFFFF_FFFF_FFFF_F00D);
    do_load("lw",  2'd2, 1'b0, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    do_load("lwu", 2'd2, 1'b1, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);

    // SH at offset 6: strobes 0xC0, data in the top halfword; store returns rdata 0.
    issue(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
    check("sh req", o_mem_req, 1'b1);
    check("sh we", o_mem_we, 1'b1);
    check("sh addr", o_mem_addr, 64'h8000_0000);
    check("sh wstrb", o_mem_wstrb, 8'hC0);
    check("sh wdata", o_mem_wdata, 64'hBEEF_0000_0000_0000);
    tick();
    check("sh held req", o_mem_req, 1'b1);
    check("sh held wstrb", o_mem_wstrb, 8'hC0);
    respond(64'h1234_5678_9ABC_DEF0, 1'b0);
    check("sh valid", o_valid, 1'b1);
    check("sh err", o_err, 1'b0);
    check("sh rdata", o_rdata, 64'h0);
    release_resp("sh");

    // gnt and rvalid together in REQ: that rvalid is not the response.
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0);
    i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    tick();
    check("gnt+rv still waiting", o_valid, 1'b0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h5555_6666_7777_8888;
    tick();
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    check("gnt+rv valid", o_valid, 1'b1);
    check("gnt+rv rdata", o_rdata, 64'h5555_6666_7777_8888);
    release_resp("gnt+rv");

    // Timeout: gnt withheld; o_mem_req stays high exactly 255 cycles.
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0020, 64'h0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!o_mem_req) break;
      n++;
      tick();
    end
    check("timeout req cycles", 64'(n), 64'd255);
    check("timeout req dropped", o_mem_req, 1'b0);
    check("timeout valid", o_valid, 1'b1);
    check("timeout err", o_err, 1'b1);
    check("timeout rdata", o_rdata, 64'h0);
    release_resp("timeout");

    // Bus error on a load; response held stable with i_ready low, stray rvalid ignored.
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0);
    respond(64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("buserr hold valid", o_valid, 1'b1);
      check("buserr hold err", o_err, 1'b1);
      check("buserr hold rdata", o_rdata, 64'h0);
      i_mem_rvalid = (i == 2); i_mem_rdata = 64'h0123_4567_89AB_CDEF;
      tick();
      i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    end
    release_resp("buserr");

    // SW at offset 2.
    issue(1'b1, 2'd2, 1'b0, 64'h8000_0002, 64'h0000_0000_CAFE_BABE);
`ifdef LSU_MISALIGN_CHK_EN
    check("sw misalign req", o_mem_req, 1'b0);
    check("sw misalign valid", o_valid, 1'b1);
    check("sw misalign err", o_err, 1'b1);
    check("sw misalign rdata", o_rdata, 64'h0);
`else
    check("sw round req", o_mem_req, 1'b1);
    check("sw round wstrb", o_mem_wstrb, 8'h0F);
    check("sw round wdata", o_mem_wdata, 64'h0000_0000_CAFE_BABE);
    check("sw round addr", o_mem_addr, 64'h8000_0000);
    respond(64'h0, 1'b0);
    check("sw round valid", o_valid, 1'b1);
    check("sw round err", o_err, 1'b0);
`endif
    release_resp("sw");

    // Reset asserted in WAIT; a late response afterwards is ignored.
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0028, 64'h0);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    check("rstwait in wait", o_mem_req, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check("rstwait ready", o_ready, 1'b1);
    check("rstwait valid", o_valid, 1'b0);
    check("rstwait addr", o_mem_addr, 64'h0);
    tick();
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_err = 1'b1; i_mem_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    i_mem_rvalid = 1'b0; i_mem_err = 1'b0; i_mem_rdata = '0;
    check("late rvalid valid", o_valid, 1'b0);
    check("late rvalid ready", o_ready, 1'b1);
    check("late rvalid err", o_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
